seq_detect_sched: RTL and testbench



---
 rtl/seq_detect_sched_pkg.sv | 40 ++++
 rtl/seq_detect_sched_rr_arbiter.sv | 31 +++
 rtl/seq_detect_sched.sv | 99 +++++++++
 tb/tb_seq_detect_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_sched_pkg.sv
// Shared definitions for the 2-bit-symbol sequence detector.
// The standalone detector and the multi-stream scheduler both use det_next.
package seq_detect_sched_pkg;

  localparam int SYM_W = 2;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_e;

  // S3 is sticky: only a clear or reset leaves it.
  function automatic det_state_e det_next(input det_state_e st, input logic [SYM_W-1:0] sym);
    det_state_e nxt;
    nxt = st;
    case (st)
      S0: nxt = (sym == 2'd1) ? S1 : S0;
      S1: begin
        case (sym)
          2'd2:    nxt = S2;
          2'd3:    nxt = S0;
          default: nxt = S1;
        endcase
      end
      S2: begin
        case (sym)
          2'd1:    nxt = S1;
          2'd2:    nxt = S0;
          2'd3:    nxt = S3;
          default: nxt = S2;
        endcase
      end
      default: nxt = S3;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant
// and wraps; the first active request wins.
module seq_detect_sched_rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] last_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [CH_W-1:0] gnt_idx_o,
  output logic            gnt_any_o
);

  logic [CH_W-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = CH_W'((int'(last_i) + k) % N_CH);
      if (!gnt_any_o && req_i[idx]) begin
        gnt_any_o  = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// One shared sequence-detector next-state function time-multiplexed over
// N_CH symbol streams, each with its own saved state, via round-robin.
//
// state | meaning
// S0    | idle, nothing matched
// S1    | seen 1
// S2    | seen 1,2
// S3    | seen 1,2,3 (sticky match)
module seq_detect_sched
  import seq_detect_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       req_valid,
  input  logic [SYM_W*N_CH-1:0] req_num,
  output logic [N_CH-1:0]       req_ready,
  input  logic [N_CH-1:0]       ch_clr,
  output logic [N_CH-1:0]       match,
  output logic                  hit_valid,
  output logic [CH_W-1:0]       hit_ch,
  output logic                  busy
);

  det_state_e       state_q [N_CH];
  det_state_e       state_d [N_CH];
  logic [CH_W-1:0]  last_grant_q, last_grant_d;
  logic             hit_valid_q, hit_valid_d;
  logic [CH_W-1:0]  hit_ch_q, hit_ch_d;
  logic [SYM_W-1:0] sym [N_CH];
  logic [N_CH-1:0]  gnt;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_any;
  det_state_e       cur_st, nxt_st;

  for (genvar g = 0; g < N_CH; g++) begin : g_sym
    assign sym[g] = req_num[SYM_W*g +: SYM_W];
  end

  seq_detect_sched_rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req_i     (req_valid),
    .last_i    (last_grant_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // No handshake can complete while reset is held.
  assign req_ready = gnt & {N_CH{rst_n}};
  assign busy      = |req_valid;
  assign hit_valid = hit_valid_q;
  assign hit_ch    = hit_ch_q;

  always_comb begin
    cur_st       = state_q[gnt_idx];
    nxt_st       = det_next(cur_st, sym[gnt_idx]);
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hit_valid_d  = 1'b0;
    hit_ch_d     = hit_ch_q;
    if (gnt_any) begin
      last_grant_d     = gnt_idx;
      state_d[gnt_idx] = nxt_st;
      if (cur_st != S3 && nxt_st == S3 && !ch_clr[gnt_idx]) begin
        hit_valid_d = 1'b1;
        hit_ch_d    = gnt_idx;
      end
    end
    // Clear wins over a coincident grant; the symbol is still consumed.
    for (int i = 0; i < N_CH; i++) begin
      if (ch_clr[i]) state_d[i] = S0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= S0;
      last_grant_q <= CH_W'(N_CH - 1);
      hit_valid_q  <= 1'b0;
      hit_ch_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hit_valid_q  <= hit_valid_d;
      hit_ch_q     <= hit_ch_d;
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < N_CH; i++) match[i] = (state_q[i] == S3);
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched: expected grants and hits are queued
// by the stimulus and popped by a negedge monitor when the DUT presents them.
module tb_seq_detect_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid, req_ready, ch_clr, match;
  logic [7:0] req_num;
  logic       hit_valid, busy;
  logic [1:0] hit_ch;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_gnt[$];
  int exp_hit[$];

  always #5 clk = ~clk;

  seq_detect_sched #(.N_CH(4), .CH_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_num   (req_num),
    .req_ready (req_ready),
    .ch_clr    (ch_clr),
    .match     (match),
    .hit_valid (hit_valid),
    .hit_ch    (hit_ch),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pk(input int s0, input int s1, input int s2, input int s3);
    return {s3[1:0], s2[1:0], s1[1:0], s0[1:0]};
  endfunction

  // Drive one cycle of stimulus, queue expectations, return at edge+1.
  task automatic step(input logic [3:0] v, input logic [7:0] n, input logic [3:0] c,
                      input int eg, input int eh);
    req_valid = v;
    req_num   = n;
    ch_clr    = c;
    if (eg >= 0) exp_gnt.push_back(eg);
    if (eh >= 0) exp_hit.push_back(eh);
    @(posedge clk);
    #1;
    req_valid = '0;
    ch_clr    = '0;
  endtask

  always @(negedge clk) begin
    int g;
    int h;
    if (rst_n === 1'b1) begin
      if (req_ready != 4'b0) begin
        if (exp_gnt.size() == 0) chk("unexpected_grant", req_ready, 0);
        else begin
          g = exp_gnt.pop_front();
          chk("grant", req_ready, 32'(1 << g));
        end
      end
      if (hit_valid) begin
        if (exp_hit.size() == 0) chk("unexpected_hit", hit_valid, 0);
        else begin
          h = exp_hit.pop_front();
          chk("hit_ch", hit_ch, h);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hf;
    req_num   = '0;
    ch_clr    = '0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_match", match, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit_ch", hit_ch, 0);
    chk("rst_busy", busy, 1);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: stream 0 alone sends 1,2,3
    step(4'b0001, pk(1,0,0,0), 4'b0, 0, -1);
    step(4'b0001, pk(2,0,0,0), 4'b0, 0, -1);
    chk("t1_match_before", match, 0);
    step(4'b0001, pk(3,0,0,0), 4'b0, 0, 0);
    chk("t1_match", match, 4'b0001);
    chk("t1_hit_pulse", hit_valid, 1);
    step(4'b0001, pk(3,0,0,0), 4'b0, 0, -1);
    chk("t1_hit_one_cycle", hit_valid, 0);
    step(4'b0001, pk(1,0,0,0), 4'b0, 0, -1);
    chk("t1_sticky", match, 4'b0001);

    // 2: all streams valid, grants rotate 0,1,2,3,...
    step(4'b0000, 8'h00, 4'b0001, -1, -1);
    chk("t2_clear", match, 0);
    step(4'b1000, 8'h00, 4'b0, 3, -1);
    for (int c = 0; c < 11; c++) begin
      int s;
      s = (c < 4) ? 1 : (c < 8) ? 2 : 3;
      step(4'hf, pk(0,0,s,0), 4'b0, c % 4, (c == 10) ? 2 : -1);
      if (c == 9) chk("t2_match_before", match, 0);
    end
    chk("t2_match", match, 4'b0100);

    // 3: interleaved streams 1 and 3 from last_grant=3
    step(4'b0000, 8'h00, 4'hf, -1, -1);
    step(4'b1000, 8'h00, 4'b0, 3, -1);
    step(4'b1010, pk(0,1,0,1), 4'b0, 1, -1);
    step(4'b1010, pk(0,2,0,1), 4'b0, 3, -1);
    step(4'b1010, pk(0,2,0,3), 4'b0, 1, -1);
    step(4'b1010, pk(0,2,0,3), 4'b0, 3, -1);
    step(4'b1010, pk(0,2,0,1), 4'b0, 1, -1);
    chk("t3_match_mid", match, 0);
    step(4'b1000, pk(0,0,0,1), 4'b0, 3, -1);
    step(4'b1000, pk(0,0,0,2), 4'b0, 3, -1);
    step(4'b1000, pk(0,0,0,3), 4'b0, 3, 3);
    chk("t3_match", match, 4'b1000);

    // 4: clear coincides with the S2->S3 symbol on stream 1
    step(4'b0010, pk(0,1,0,0), 4'b0, 1, -1);
    step(4'b0010, pk(0,2,0,0), 4'b0, 1, -1);
    step(4'b0010, pk(0,3,0,0), 4'b0010, 1, -1);
    chk("t4_clr_no_hit", hit_valid, 0);
    chk("t4_match", match, 4'b1000);
    chk("t4_hit_ch_hold", hit_ch, 3);
    step(4'b0010, pk(0,1,0,0), 4'b0, 1, -1);
    step(4'b0010, pk(0,2,0,0), 4'b0, 1, -1);
    step(4'b0010, pk(0,3,0,0), 4'b0, 1, 1);
    chk("t4_match_after", match, 4'b1010);

    // 5: stream 0 to S3, clear, idle keeps last_grant
    step(4'b0001, pk(1,0,0,0), 4'b0, 0, -1);
    step(4'b0001, pk(2,0,0,0), 4'b0, 0, -1);
    step(4'b0001, pk(3,0,0,0), 4'b0, 0, 0);
    chk("t5_match", match, 4'b1011);
    step(4'b0000, 8'h00, 4'b0001, -1, -1);
    chk("t5_cleared", match, 4'b1010);
    step(4'b0000, 8'h00, 4'b0, -1, -1);
    step(4'b0000, 8'h00, 4'b0, -1, -1);
    chk("t5_busy_idle", busy, 0);
    step(4'b1001, 8'h00, 4'b0, 3, -1);
    chk("t5_match_after", match, 4'b1010);

    // 6: asynchronous reset with stream 2 in S2 and a grant pending
    step(4'b0100, pk(0,0,1,0), 4'b0, 2, -1);
    step(4'b0100, pk(0,0,2,0), 4'b0, 2, -1);
    chk("t6_match_pre", match, 4'b1010);
    req_valid = 4'b0100;
    req_num   = pk(0,0,3,0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_match", match, 0);
    chk("t6_rst_hit", hit_valid, 0);
    chk("t6_rst_ready", req_ready, 0);
    req_valid = 4'b1100;
    req_num   = pk(0,0,3,0);
    @(posedge clk);
    #1;
    exp_gnt.push_back(2);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_no_hit", hit_valid, 0);
    step(4'b1000, pk(0,0,0,0), 4'b0, 3, -1);
    chk("t6_match_after", match, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("gnt_queue_drained", exp_gnt.size(), 0);
    chk("hit_queue_drained", exp_hit.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
